// File: rtl/div_iter_pkg.sv
// ============================================================================
// Module  : div_iter_pkg
// Purpose : Op encodings and FSM state encoding shared by the div_iter block.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package div_iter_pkg;

  localparam logic [2:0] INST_DIV  = 3'b100;
  localparam logic [2:0] INST_DIVU = 3'b101;
  localparam logic [2:0] INST_REM  = 3'b110;
  localparam logic [2:0] INST_REMU = 3'b111;

  typedef enum logic [4:0] {
    S_IDLE = 5'b00001,
    S_PREP = 5'b00010,
    S_CALC = 5'b00100,
    S_FIX  = 5'b01000,
    S_DONE = 5'b10000
  } state_e;

endpackage

`default_nettype wire

// File: rtl/div_lzc.sv
// ============================================================================
// Module  : div_lzc
// Purpose : Parametrised leading-zero counter; all-zero input yields XLEN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module div_lzc #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]          i_val,
  output logic [$clog2(XLEN):0]    o_lz
);

  localparam int LZ_W = $clog2(XLEN) + 1;

  // Scanning upward lets the most significant set bit win.
  always_comb begin
    o_lz = LZ_W'(XLEN);
    for (int i = 0; i < XLEN; i++) begin
      if (i_val[i]) o_lz = LZ_W'(XLEN - 1 - i);
    end
  end

endmodule

`default_nettype wire

// File: rtl/div_iter.sv
// ============================================================================
// Module  : div_iter
// Purpose : Iterative restoring divider (DIV/DIVU/REM/REMU), valid/ready + kill.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module div_iter
  import div_iter_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int UNROLL    = 1,
  parameter int EARLY_OUT = 1,
  parameter int TAG_W     = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [XLEN-1:0]  in_dividend,
  input  logic [XLEN-1:0]  in_divisor,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             kill,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int LZ_W  = $clog2(XLEN) + 1;
  localparam int CNT_W = $clog2(XLEN) + 2;
  localparam int UL    = $clog2(UNROLL);

  state_e             r_state, w_next;
  logic [2:0]         r_op;
  logic [XLEN-1:0]    r_a, r_b;
  logic [XLEN:0]      r_rem, r_dvs;
  logic [XLEN-1:0]    r_dvd, r_quo, r_result;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_neg_q, r_neg_r;
  logic [TAG_W-1:0]   r_out_tag;

  logic               w_is_signed, w_sel_rem, w_dvd_neg, w_dvs_neg;
  logic [XLEN-1:0]    w_a_mag, w_b_mag;
  logic               w_div_zero, w_ovf, w_zero_out, w_special;
  logic [XLEN-1:0]    w_spec_res;
  logic [LZ_W-1:0]    w_lz;
  logic [CNT_W-1:0]   w_sig, w_n_raw, w_n, w_shift;
  logic [XLEN:0]      w_rem_c, w_trial;
  logic [XLEN-1:0]    w_dvd_c, w_quo_c, w_q_fin, w_r_fin;

  assign w_is_signed = (r_op == INST_DIV) || (r_op == INST_REM);
  assign w_sel_rem   = (r_op == INST_REM) || (r_op == INST_REMU);
  assign w_dvd_neg   = w_is_signed & r_a[XLEN-1];
  assign w_dvs_neg   = w_is_signed & r_b[XLEN-1];
  assign w_a_mag     = w_dvd_neg ? -r_a : r_a;
  assign w_b_mag     = w_dvs_neg ? -r_b : r_b;

  assign w_div_zero  = (r_b == '0);
  assign w_ovf       = w_is_signed && (r_a == {1'b1, {(XLEN-1){1'b0}}}) && (r_b == '1);
  assign w_zero_out  = (EARLY_OUT != 0) && (r_a == '0);
  assign w_special   = w_div_zero | w_ovf | w_zero_out;

  always_comb begin
    w_spec_res = '0;
    if (w_div_zero)  w_spec_res = w_sel_rem ? r_a : '1;
    else if (w_ovf)  w_spec_res = w_sel_rem ? '0 : r_a;
  end

  generate
    if (EARLY_OUT != 0) begin : g_lzc
      div_lzc #(.XLEN(XLEN)) u_lzc (
        .i_val (w_a_mag),
        .o_lz  (w_lz)
      );
    end else begin : g_no_lzc
      assign w_lz = '0;
    end
  endgenerate

  // Iterations cover only the significant bits; the dividend is left-aligned
  // so the unused leading groups never enter the partial remainder.
  assign w_sig   = CNT_W'(XLEN) - CNT_W'(w_lz);
  assign w_n_raw = (w_sig + CNT_W'(UNROLL - 1)) >> UL;
  assign w_n     = (w_n_raw == '0) ? CNT_W'(1) : w_n_raw;
  assign w_shift = CNT_W'(XLEN) - (w_n << UL);

  always_comb begin
    w_rem_c = r_rem;
    w_dvd_c = r_dvd;
    w_quo_c = r_quo;
    w_trial = '0;
    for (int k = 0; k < UNROLL; k++) begin
      w_trial = (XLEN+1)'({w_rem_c, w_dvd_c[XLEN-1]});
      w_dvd_c = w_dvd_c << 1;
      if (w_trial >= r_dvs) begin
        w_rem_c = w_trial - r_dvs;
        w_quo_c = {w_quo_c[XLEN-2:0], 1'b1};
      end else begin
        w_rem_c = w_trial;
        w_quo_c = {w_quo_c[XLEN-2:0], 1'b0};
      end
    end
  end

  assign w_q_fin = r_neg_q ? -r_quo : r_quo;
  assign w_r_fin = r_neg_r ? -r_rem[XLEN-1:0] : r_rem[XLEN-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_next = S_PREP;
      S_PREP:  w_next = w_special ? S_DONE : S_CALC;
      S_CALC:  if (r_cnt == CNT_W'(1)) w_next = S_FIX;
      S_FIX:   w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (kill) w_next = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_rem     <= '0;
      r_dvs     <= '0;
      r_dvd     <= '0;
      r_quo     <= '0;
      r_cnt     <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_result  <= '0;
      r_out_tag <= '0;
    end else if (!kill) begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_op      <= in_op;
            r_a       <= in_dividend;
            r_b       <= in_divisor;
            r_out_tag <= in_tag;
          end
        end
        S_PREP: begin
          if (w_special) begin
            r_result <= w_spec_res;
          end else begin
            r_rem   <= '0;
            r_quo   <= '0;
            r_dvd   <= w_a_mag << w_shift;
            r_dvs   <= {1'b0, w_b_mag};
            r_cnt   <= w_n;
            r_neg_q <= w_dvd_neg ^ w_dvs_neg;
            r_neg_r <= w_dvd_neg;
          end
        end
        S_CALC: begin
          r_rem <= w_rem_c;
          r_dvd <= w_dvd_c;
          r_quo <= w_quo_c;
          r_cnt <= r_cnt - CNT_W'(1);
        end
        S_FIX:   r_result <= w_sel_rem ? w_r_fin : w_q_fin;
        default: ;
      endcase
    end
  end

  assign in_ready   = (r_state == S_IDLE);
  assign out_valid  = (r_state == S_DONE);
  assign busy       = (r_state != S_IDLE);
  assign out_result = r_result;
  assign out_tag    = r_out_tag;

endmodule

`default_nettype wire

// File: tb/tb_div_iter.sv
// ============================================================================
// Module  : tb_div_iter
// Purpose : Self-checking bench; two div_iter configurations run in lockstep.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_div_iter;
  import div_iter_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        kill = 1'b0;
  logic        out_ready = 1'b0;
  logic [2:0]  in_op = 3'b0;
  logic [31:0] in_dividend = 32'h0;
  logic [31:0] in_divisor = 32'h0;
  logic [4:0]  in_tag = 5'h0;

  logic        a_in_ready, a_out_valid, a_busy;
  logic [31:0] a_out_result;
  logic [4:0]  a_out_tag;
  logic        b_in_ready, b_out_valid, b_busy;
  logic [31:0] b_out_result;
  logic [4:0]  b_out_tag;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  div_iter #(.XLEN(32), .UNROLL(1), .EARLY_OUT(0), .TAG_W(5)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready), .in_op(in_op),
    .in_dividend(in_dividend), .in_divisor(in_divisor), .in_tag(in_tag), .kill(kill),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_result(a_out_result),
    .out_tag(a_out_tag), .busy(a_busy));

  div_iter #(.XLEN(32), .UNROLL(4), .EARLY_OUT(1), .TAG_W(5)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .in_op(in_op),
    .in_dividend(in_dividend), .in_divisor(in_divisor), .in_tag(in_tag), .kill(kill),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_result(b_out_result),
    .out_tag(b_out_tag), .busy(b_busy));

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // RISC-V division semantics from plain 64-bit arithmetic.
  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, q, r;
    logic   sgn;
    sgn = (op == INST_DIV) || (op == INST_REM);
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = {32'h0, a};
      sb = {32'h0, b};
    end
    if (b == 32'h0) begin
      q = -1;
      r = sa;
    end else begin
      q = sa / sb;
      r = sa % sb;
    end
    return ((op == INST_REM) || (op == INST_REMU)) ? r[31:0] : q[31:0];
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input int unroll, input bit early);
    longint m;
    int     sig, n;
    logic   sgn;
    sgn = (op == INST_DIV) || (op == INST_REM);
    if (b == 32'h0) return 2;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
    if (early && a == 32'h0) return 2;
    if (!early) return 32 / unroll + 3;
    m = sgn ? longint'($signed(a)) : longint'({32'h0, a});
    if (m < 0) m = -m;
    sig = 0;
    for (int i = 0; i < 40; i++) if (m[i]) sig = i + 1;
    n = (sig + unroll - 1) / unroll;
    if (n < 1) n = 1;
    return n + 3;
  endfunction

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input logic [31:0] exp, input int hold);
    int la, lb, cyc;
    bit da, db;
    la = ref_lat(op, a, b, 1, 1'b0);
    lb = ref_lat(op, a, b, 4, 1'b1);
    check_eq("in_ready_a", a_in_ready, 1);
    check_eq("in_ready_b", b_in_ready, 1);
    in_op = op; in_dividend = a; in_divisor = b; in_tag = tag; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 1; da = 1'b0; db = 1'b0;
    while ((!da || !db) && cyc < 100) begin
      if (a_out_valid && !da) begin
        da = 1'b1;
        check_eq("lat_a", cyc, la);
        check_eq("res_a", a_out_result, exp);
        check_eq("tag_a", a_out_tag, tag);
      end
      if (b_out_valid && !db) begin
        db = 1'b1;
        check_eq("lat_b", cyc, lb);
        check_eq("res_b", b_out_result, exp);
        check_eq("tag_b", b_out_tag, tag);
      end
      if (!da || !db) begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    check_eq("done_a", da, 1);
    check_eq("done_b", db, 1);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check_eq("hold_res_a", a_out_result, exp);
      check_eq("hold_tag_b", b_out_tag, tag);
      check_eq("hold_vld_b", b_out_valid, 1);
      check_eq("hold_rdy_a", a_in_ready, 0);
      check_eq("hold_rdy_b", b_in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq("drop_vld_a", a_out_valid, 0);
    check_eq("drop_vld_b", b_out_valid, 0);
  endtask

  function automatic logic [31:0] pick(input int kind);
    case (kind)
      0, 1:    return $urandom;
      2:       return 32'($urandom_range(0, 255));
      3:       return 32'h0;
      4:       return 32'h8000_0000;
      default: return 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
    endcase
  endfunction

  initial begin
    logic [1:0]  sel;
    logic [2:0]  op;
    logic [31:0] a, b;
    bit          seen;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_eq("rst_in_ready_a", a_in_ready, 1);
    check_eq("rst_out_valid_a", a_out_valid, 0);
    check_eq("rst_busy_a", a_busy, 0);
    check_eq("rst_result_a", a_out_result, 0);
    check_eq("rst_tag_a", a_out_tag, 0);
    check_eq("rst_busy_b", b_busy, 0);
    check_eq("rst_result_b", b_out_result, 0);

    run_op(INST_DIVU, 32'd100, 32'd7, 5'd1, 32'd14, 0);
    run_op(INST_REMU, 32'd100, 32'd7, 5'd2, 32'd2, 0);
    run_op(INST_DIV, 32'hFFFF_FFF9, 32'd2, 5'd3, 32'hFFFF_FFFD, 0);
    run_op(INST_REM, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFF, 0);
    run_op(INST_DIV, 32'd7, 32'hFFFF_FFFE, 5'd5, 32'hFFFF_FFFD, 0);
    run_op(INST_DIV, 32'd5, 32'd0, 5'd6, 32'hFFFF_FFFF, 0);
    run_op(INST_REM, 32'd5, 32'd0, 5'd7, 32'd5, 0);
    run_op(INST_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'h8000_0000, 0);
    run_op(INST_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32'h0, 0);
    run_op(INST_DIVU, 32'h0000_00FF, 32'd3, 5'd21, 32'h55, 0);
    run_op(INST_REMU, 32'hDEAD_BEEF, 32'd1000, 5'd30, ref_result(INST_REMU, 32'hDEAD_BEEF, 32'd1000), 10);

    // Kill mid-CALC: both configurations still iterating at this point.
    in_op = INST_DIVU; in_dividend = 32'hFFFF_FFF0; in_divisor = 32'd3; in_tag = 5'd17;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    check_eq("calc_busy_a", a_busy, 1);
    check_eq("calc_busy_b", b_busy, 1);
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    check_eq("kill_busy_a", a_busy, 0);
    check_eq("kill_busy_b", b_busy, 0);
    check_eq("kill_rdy_a", a_in_ready, 1);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (a_out_valid || b_out_valid || a_busy || b_busy) seen = 1'b1;
    end
    check_eq("kill_quiet", seen, 0);

    // A request presented together with kill is dropped.
    in_op = INST_DIV; in_dividend = 32'd50; in_divisor = 32'd5; in_valid = 1'b1; kill = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; kill = 1'b0;
    check_eq("kill_idle_busy_a", a_busy, 0);
    check_eq("kill_idle_busy_b", b_busy, 0);

    run_op(INST_DIVU, 32'hFFFF_FFF0, 32'd3, 5'd18, 32'h5555_5550, 0);

    for (int t = 0; t < 60; t++) begin
      sel = 2'($urandom_range(0, 3));
      op  = {1'b1, sel};
      a   = pick($urandom_range(0, 5));
      b   = pick($urandom_range(0, 5));
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 17));
      run_op(op, a, b, 5'($urandom), ref_result(op, a, b), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

`default_nettype wire
